// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM states and op classification helpers for the mul/div engine
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        MADD  = 3'd2,
        MADDU = 3'd3,
        MSUB  = 3'd4,
        MSUBU = 3'd5,
        DIV   = 3'd6,
        DIVU  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL      = 3'd1,
        S_DIV_ZERO = 3'd2,
        S_DIV_ON   = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    function automatic logic is_signed(input op_t op);
        return (op == MULT) || (op == MADD) || (op == MSUB) || (op == DIV);
    endfunction

    function automatic logic is_div(input op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - iterative restoring radix-2 divider on unsigned magnitudes
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // quotient/remainder are the values after the current step, so the
    // caller can capture the final result on the same edge as the last step
    always_comb begin
        shifted   = {rem, quo[WIDTH-1]};
        diff      = shifted - {1'b0, dvs};
        fits      = ~diff[WIDTH];
        quotient  = {quo[WIDTH-2:0], fits};
        remainder = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        last      = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
            cnt <= '0;
        end else if (step) begin
            rem <= remainder;
            quo <= quotient;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - sequential multiply/accumulate/divide engine with start/ready handshake
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    state_t             state, state_n;
    op_t                op_in, op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt;
    logic               mul_last;

    logic               sgn_in, sgn_q;
    logic               div_load, div_step, div_last;
    logic [WIDTH-1:0]   div_a, div_b, div_quo, div_rem;
    logic [WIDTH-1:0]   ma, mb;
    logic [2*WIDTH-1:0] prod_u, prod, mul_res, div_res;
    logic               neg_prod;

    assign op_in    = op_t'(op_i);
    assign sgn_in   = is_signed(op_in);
    assign sgn_q    = is_signed(op_q);
    assign mul_last = (cnt == CW'(MUL_STAGES - 1));
    assign busy_o   = (state == S_MUL) || (state == S_DIV_ZERO) || (state == S_DIV_ON);

    // the divider loads straight from the request so its first step is the next edge
    assign div_a    = (sgn_in && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign div_b    = (sgn_in && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign div_load = (state == S_IDLE) && start_i && !annul_i && is_div(op_in) && (opdata2_i != '0);
    assign div_step = (state == S_DIV_ON) && !annul_i;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .step      (div_step),
        .dividend  (div_a),
        .divisor   (div_b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    always_comb begin
        ma       = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        mb       = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        neg_prod = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        prod_u   = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
        prod     = neg_prod ? -prod_u : prod_u;
        case (op_q)
            MADD, MADDU: mul_res = acc_q + prod;
            MSUB, MSUBU: mul_res = acc_q - prod;
            default:     mul_res = prod;
        endcase
        // quotient sign follows the operand signs, remainder follows the dividend
        div_res = {(sgn_q && a_q[WIDTH-1]) ? -div_rem : div_rem,
                   neg_prod ? -div_quo : div_quo};
    end

    always_comb begin
        state_n = state;
        if (annul_i) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (!is_div(op_in))          state_n = S_MUL;
                        else if (opdata2_i == '0)    state_n = S_DIV_ZERO;
                        else                         state_n = S_DIV_ON;
                    end
                end
                S_MUL:      if (mul_last) state_n = S_DONE;
                S_DIV_ZERO: state_n = S_DONE;
                S_DIV_ON:   if (div_last) state_n = S_DONE;
                S_DONE:     if (!start_i) state_n = S_IDLE;
                default:    state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= MULT;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state <= state_n;
            if (annul_i) begin
                cnt      <= '0;
                result_o <= '0;
                ready_o  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            op_q  <= op_in;
                            a_q   <= opdata1_i;
                            b_q   <= opdata2_i;
                            acc_q <= acc_i;
                            cnt   <= '0;
                        end
                    end
                    S_MUL: begin
                        cnt <= cnt + 1'b1;
                        if (mul_last) result_o <= mul_res;
                    end
                    S_DIV_ZERO: result_o <= '0;
                    S_DIV_ON:   if (div_last) result_o <= div_res;
                    S_DONE:     ready_o <= start_i;
                    default:    ready_o <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit at WIDTH=32, MUL_STAGES=2
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] acc;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .op_i      (op),
        .opdata1_i (a),
        .opdata2_i (b),
        .acc_i     (acc),
        .annul_i   (annul),
        .result_o  (result),
        .ready_o   (ready),
        .busy_o    (busy)
    );

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        logic [63:0] res;
        int          lat;
        int          busy;
        int          hold;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int lat = 0;
        int busyc = 0;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; acc = v.acc; start = 1'b1;
        @(posedge clk); #1;
        if (busy) busyc++;
        // scramble inputs after the latch edge; the engine must ignore them
        a = 32'h5A5A_1234; b = 32'h0; acc = 64'hDEAD_BEEF_0000_0001; op = 3'd1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = n;
                break;
            end
            if (busy) busyc++;
        end
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d result", idx), result, v.res);
        check($sformatf("v%0d busy cycles", idx), 64'(busyc), 64'(v.busy));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            check($sformatf("v%0d hold ready", idx), 64'(ready), 64'd1);
            check($sformatf("v%0d hold result", idx), result, v.res);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d ready drop", idx), 64'(ready), 64'd0);
        check($sformatf("v%0d result kept", idx), result, v.res);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'h0, 64'hFFFF_FFFF_FFFF_FFFD, 33, 32, 0};
        vecs[1]  = '{DIVU,  32'd100,       32'h0,         64'h0, 64'h0,                  2,  1,  0};
        vecs[2]  = '{MADD,  32'hFFFF_FFFD, 32'h0000_0004, 64'h5, 64'hFFFF_FFFF_FFFF_FFF9, 3,  2,  0};
        vecs[3]  = '{MSUBU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0, 64'hFFFF_FFFE_0000_0002, 3,  2,  0};
        vecs[4]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 64'h0000_0000_8000_0000, 33, 32, 5};
        vecs[5]  = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'h0000_0000_0000_0001, 3,  2,  0};
        vecs[6]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001, 3,  2,  0};
        vecs[7]  = '{MULT,  32'h0000_0007, 32'hFFFF_FFFE, 64'h0, 64'hFFFF_FFFF_FFFF_FFF2, 3,  2,  0};
        vecs[8]  = '{MADDU, 32'h0000_0001, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3, 2, 0};
        vecs[9]  = '{MSUB,  32'hFFFF_FFFE, 32'h0000_0003, 64'h0, 64'h0000_0000_0000_0006, 3,  2,  0};
        vecs[10] = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0, 64'h0000_0001_FFFF_FFFD, 33, 32, 0};
        vecs[11] = '{DIV,   32'h0000_0005, 32'h0,         64'h0, 64'h0,                  2,  1,  0};
        vecs[12] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 64'h0, 64'h0000_0000_FFFF_FFFF, 33, 32, 0};
        vecs[13] = '{MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0, 64'h0000_0001_0000_0000, 3,  2,  0};

        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; acc = '0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result, 64'h0);
        check("reset ready", 64'(ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_op(i, vecs[i]);

        // annul in the tenth DIV_ON cycle, then a fresh divide must work
        @(negedge clk);
        op = DIV; a = 32'd1000; b = 32'd7; acc = '0; start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        check("annul busy", 64'(busy), 64'd0);
        check("annul ready", 64'(ready), 64'd0);
        check("annul result", result, 64'h0);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ready || busy) seen = 1;
        end
        check("annul stays idle", 64'(seen), 64'd0);
        run_op(14, '{DIVU, 32'd10, 32'd3, 64'h0, 64'h0000_0001_0000_0003, 33, 32, 0});

        // synchronous reset in the middle of a divide
        @(negedge clk);
        op = DIVU; a = 32'd12345; b = 32'd17; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst mid result", result, 64'h0);
        check("rst mid ready", 64'(ready), 64'd0);
        check("rst mid busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        run_op(15, '{MULTU, 32'd6, 32'd7, 64'h0, 64'd42, 3, 2, 0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
